// File: rtl/alu_pkg.sv
// Shared decode vocabulary: aluop/funct codes, ALU control encodings,
// the per-lane decode result and the issue-stage state names.
package alu_pkg;

    // aluop codes; any aluop with both upper bits set selects funct decode
    localparam logic [2:0] ALUOP_ADD = 3'b000;
    localparam logic [2:0] ALUOP_AND = 3'b001;
    localparam logic [2:0] ALUOP_MUL = 3'b010;
    localparam logic [2:0] ALUOP_OR  = 3'b011;
    localparam logic [2:0] ALUOP_XOR = 3'b100;
    localparam logic [2:0] ALUOP_LUI = 3'b101;

    // R-type funct codes
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV = 6'b000110;
    localparam logic [5:0] FUNCT_SRAV = 6'b000111;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;
    localparam logic [5:0] FUNCT_JALR = 6'b001001;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;

    // ALU control encodings; AND is zero so a cleared lane reads as AND
    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_XOR   = 4'b0011,
        ALU_SLL   = 4'b0100,
        ALU_SLLV  = 4'b0101,
        ALU_SUB   = 4'b0110,
        ALU_SLT   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRLV  = 4'b1001,
        ALU_SRA   = 4'b1010,
        ALU_SRAV  = 4'b1011,
        ALU_PASSB = 4'b1100
    } alu_ctl_e;

    // Everything one lane decodes to
    typedef struct packed {
        logic     ismultiply;
        alu_ctl_e alucontrol;
        logic     jr;
        logic     alusrc2;
        logic     illegal;
    } lane_dec_t;

    // Issue-stage states: nothing held, bundle held at first beat, bundle mid-split
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FULL  = 2'd1,
        ST_SPLIT = 2'd2
    } stage_state_e;

endpackage

// File: rtl/alu_lane_dec.sv
// Single-lane combinational decoder from aluop/funct to ALU controls.
module alu_lane_dec
    import alu_pkg::*;
(
    input  logic       lane_valid_i,
    input  logic [2:0] aluop_i,
    input  logic [5:0] funct_i,
    output lane_dec_t  dec_o
);

    // Empty lanes stay all-zero; unknown functs raise illegal and leave every other field zero
    always_comb begin
        dec_o = '0;
        if (lane_valid_i) begin
            case (aluop_i)
                ALUOP_ADD: dec_o.alucontrol = ALU_ADD;
                ALUOP_AND: dec_o.alucontrol = ALU_AND;
                ALUOP_MUL: dec_o.ismultiply = 1'b1;
                ALUOP_OR:  dec_o.alucontrol = ALU_OR;
                ALUOP_XOR: dec_o.alucontrol = ALU_XOR;
                ALUOP_LUI: dec_o.alucontrol = ALU_PASSB;
                default: begin
                    case (funct_i)
                        FUNCT_ADD, FUNCT_ADDU: dec_o.alucontrol = ALU_ADD;
                        FUNCT_SUB:  dec_o.alucontrol = ALU_SUB;
                        FUNCT_AND:  dec_o.alucontrol = ALU_AND;
                        FUNCT_OR:   dec_o.alucontrol = ALU_OR;
                        FUNCT_SLT:  dec_o.alucontrol = ALU_SLT;
                        FUNCT_XOR:  dec_o.alucontrol = ALU_XOR;
                        FUNCT_SLL:  dec_o.alucontrol = ALU_SLL;
                        FUNCT_SLLV: dec_o.alucontrol = ALU_SLLV;
                        FUNCT_SRL:  dec_o.alucontrol = ALU_SRL;
                        FUNCT_SRLV: dec_o.alucontrol = ALU_SRLV;
                        FUNCT_SRA:  dec_o.alucontrol = ALU_SRA;
                        FUNCT_SRAV: dec_o.alucontrol = ALU_SRAV;
                        FUNCT_JR: begin
                            dec_o.alucontrol = ALU_PASSB;
                            dec_o.jr         = 1'b1;
                        end
                        FUNCT_JALR: begin
                            dec_o.alucontrol = ALU_PASSB;
                            dec_o.jr         = 1'b1;
                            dec_o.alusrc2    = 1'b1;
                        end
                        default: dec_o.illegal = 1'b1;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered multi-lane decode stage. A bundle whose multiply count exceeds
// MULS_PER_BEAT is released over several beats in lane order.
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int LANES         = 4,
    parameter int MULS_PER_BEAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES-1:0]     in_lane_valid,
    input  logic [LANES*3-1:0]   aluop,
    input  logic [LANES*6-1:0]   funct,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES-1:0]     out_lane_valid,
    output logic [LANES-1:0]     ismultiply,
    output logic [LANES*4-1:0]   alucontrol,
    output logic [LANES-1:0]     jr,
    output logic [LANES-1:0]     alusrc2,
    output logic [LANES-1:0]     illegal,
    output logic                 split_busy
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    stage_state_e            state_q, state_d;
    lane_dec_t [LANES-1:0]   decNew;
    lane_dec_t [LANES-1:0]   dec_q, dec_d;
    logic [LANES-1:0]        laneMask_q, laneMask_d;
    logic [IDX_W-1:0]        start_q, start_d;
    logic [LANES-1:0]        mulMask;
    logic [LANES-1:0]        beatMask;
    logic                    beatFinal;
    logic [IDX_W-1:0]        nextStart;
    logic                    accept;
    logic                    beatDone;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        alu_lane_dec u_dec (
            .lane_valid_i (in_lane_valid[g]),
            .aluop_i      (aluop[g*3 +: 3]),
            .funct_i      (funct[g*6 +: 6]),
            .dec_o        (decNew[g])
        );
    end

    // Gather the held multiply lanes into a flat mask for the beat planner
    always_comb begin
        mulMask = '0;
        for (int i = 0; i < LANES; i++) begin
            mulMask[i] = dec_q[i].ismultiply;
        end
    end

    // Plan the current beat: from the first unreleased lane up to just before the multiply that would exceed the per-beat limit
    always_comb begin
        int   mulSeen;
        logic cut;
        beatMask  = '0;
        beatFinal = 1'b1;
        nextStart = start_q;
        mulSeen   = 0;
        cut       = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (i >= int'(start_q) && !cut) begin
                if (mulMask[i] && mulSeen == MULS_PER_BEAT) begin
                    cut       = 1'b1;
                    beatFinal = 1'b0;
                    nextStart = IDX_W'(i);
                end else begin
                    beatMask[i] = 1'b1;
                    if (mulMask[i]) begin
                        mulSeen = mulSeen + 1;
                    end
                end
            end
        end
    end

    assign out_valid  = (state_q != ST_IDLE);
    assign in_ready   = (state_q == ST_IDLE) || (out_ready && beatFinal);
    assign accept     = in_valid && in_ready;
    assign beatDone   = out_valid && out_ready;
    assign split_busy = (state_q == ST_SPLIT) || ((state_q == ST_FULL) && !beatFinal);

    // Next state and held bundle; a new bundle may be taken on the cycle the last beat leaves
    always_comb begin
        state_d    = state_q;
        dec_d      = dec_q;
        laneMask_d = laneMask_q;
        start_d    = start_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL, ST_SPLIT: begin
                if (beatDone) begin
                    if (!beatFinal) begin
                        state_d = ST_SPLIT;
                        start_d = nextStart;
                    end else if (accept) begin
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            dec_d      = decNew;
            laneMask_d = in_lane_valid;
            start_d    = '0;
        end
    end

    // State and bundle registers; reset wins over any handshake in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dec_q      <= '0;
            laneMask_q <= '0;
            start_q    <= '0;
        end else begin
            state_q    <= state_d;
            dec_q      <= dec_d;
            laneMask_q <= laneMask_d;
            start_q    <= start_d;
        end
    end

    // Drive the held decode onto the outputs only while a beat is offered
    always_comb begin
        out_lane_valid = '0;
        ismultiply     = '0;
        alucontrol     = '0;
        jr             = '0;
        alusrc2        = '0;
        illegal        = '0;
        if (out_valid) begin
            out_lane_valid = beatMask & laneMask_q;
            for (int i = 0; i < LANES; i++) begin
                ismultiply[i]        = dec_q[i].ismultiply;
                alucontrol[i*4 +: 4] = dec_q[i].alucontrol;
                jr[i]                = dec_q[i].jr;
                alusrc2[i]           = dec_q[i].alusrc2;
                illegal[i]           = dec_q[i].illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Testbench for alu_decode_stage: directed scenarios plus random traffic
// checked against a bundle/beat-level reference model.
module tb_alu_decode_stage;

    localparam int LANES = 4;
    localparam int MULS  = 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ORI = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_R   = 3'b110;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_BAD  = 6'b111111;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES-1:0]     in_lane_valid;
    logic [LANES*3-1:0]   aluop;
    logic [LANES*6-1:0]   funct;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES-1:0]     out_lane_valid;
    logic [LANES-1:0]     ismultiply;
    logic [LANES*4-1:0]   alucontrol;
    logic [LANES-1:0]     jr;
    logic [LANES-1:0]     alusrc2;
    logic [LANES-1:0]     illegal;
    logic                 split_busy;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state: beats still owed for the held bundle and its decode
    logic [LANES-1:0]     beatQ[$];
    logic [LANES-1:0]     expMul, expJr, expSrc2, expIll;
    logic [LANES*4-1:0]   expCtl;
    bit                   expMulti;
    bit                   accNow;
    bit                   doneNow;

    logic [5:0] legalFn [15] = '{6'b100000, 6'b100001, 6'b100010, 6'b100100, 6'b100101,
                                 6'b101010, 6'b100110, 6'b000000, 6'b000100, 6'b000010,
                                 6'b000110, 6'b000011, 6'b000111, 6'b001000, 6'b001001};

    alu_decode_stage #(
        .LANES         (LANES),
        .MULS_PER_BEAT (MULS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_lane_valid  (in_lane_valid),
        .aluop          (aluop),
        .funct          (funct),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_lane_valid (out_lane_valid),
        .ismultiply     (ismultiply),
        .alucontrol     (alucontrol),
        .jr             (jr),
        .alusrc2        (alusrc2),
        .illegal        (illegal),
        .split_busy     (split_busy)
    );

    always #5 clk = ~clk;

    // Counts one comparison and reports it when observed and expected differ
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Lane meaning from the decode table: {illegal, ismultiply, alucontrol[3:0], jr, alusrc2}
    function automatic logic [7:0] refLane(input logic v, input logic [2:0] op, input logic [5:0] fn);
        if (!v) return 8'h00;
        case (op)
            3'b000: return {2'b00, 4'b0010, 2'b00};
            3'b001: return {2'b00, 4'b0000, 2'b00};
            3'b010: return {2'b01, 4'b0000, 2'b00};
            3'b011: return {2'b00, 4'b0001, 2'b00};
            3'b100: return {2'b00, 4'b0011, 2'b00};
            3'b101: return {2'b00, 4'b1100, 2'b00};
            default: begin
                case (fn)
                    6'b100000, 6'b100001: return {2'b00, 4'b0010, 2'b00};
                    6'b100010: return {2'b00, 4'b0110, 2'b00};
                    6'b100100: return {2'b00, 4'b0000, 2'b00};
                    6'b100101: return {2'b00, 4'b0001, 2'b00};
                    6'b101010: return {2'b00, 4'b0111, 2'b00};
                    6'b100110: return {2'b00, 4'b0011, 2'b00};
                    6'b000000: return {2'b00, 4'b0100, 2'b00};
                    6'b000100: return {2'b00, 4'b0101, 2'b00};
                    6'b000010: return {2'b00, 4'b1000, 2'b00};
                    6'b000110: return {2'b00, 4'b1001, 2'b00};
                    6'b000011: return {2'b00, 4'b1010, 2'b00};
                    6'b000111: return {2'b00, 4'b1011, 2'b00};
                    6'b001000: return {2'b00, 4'b1100, 2'b10};
                    6'b001001: return {2'b00, 4'b1100, 2'b11};
                    default:   return 8'b1000_0000;
                endcase
            end
        endcase
    endfunction

    function automatic logic [LANES*3-1:0] ops4(input logic [2:0] a, input logic [2:0] b,
                                                input logic [2:0] c, input logic [2:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [LANES*6-1:0] fns4(input logic [5:0] a, input logic [5:0] b,
                                                input logic [5:0] c, input logic [5:0] d);
        return {d, c, b, a};
    endfunction

    // Model a newly accepted bundle: decode every lane, then cut beats at every MULS-th multiply after the first group
    task automatic loadBundle();
        int               p[$];
        int               b[$];
        int               hi;
        logic [7:0]       r;
        logic [LANES-1:0] m;
        for (int i = 0; i < LANES; i++) begin
            r = refLane(in_lane_valid[i], aluop[i*3 +: 3], funct[i*6 +: 6]);
            expIll[i]          = r[7];
            expMul[i]          = r[6];
            expCtl[i*4 +: 4]   = r[5:2];
            expJr[i]           = r[1];
            expSrc2[i]         = r[0];
            if (r[6]) p.push_back(i);
        end
        if (p.size() <= MULS) begin
            beatQ.push_back(in_lane_valid);
        end else begin
            b.push_back(0);
            for (int j = MULS; j < p.size(); j += MULS) b.push_back(p[j]);
            for (int j = 0; j < b.size(); j++) begin
                hi = (j + 1 < b.size()) ? b[j+1] - 1 : LANES - 1;
                m  = '0;
                for (int k = b[j]; k <= hi; k++) m[k] = 1'b1;
                beatQ.push_back(m & in_lane_valid);
            end
        end
        expMulti = (beatQ.size() > 1);
    endtask

    // Drive one cycle's inputs, let them settle, and compare every output against the model
    task automatic applyStimulus(input bit iv, input logic [LANES-1:0] lv, input logic [LANES*3-1:0] op,
                                 input logic [LANES*6-1:0] fn, input bit ordy);
        bit               busy;
        bit               expInReady;
        logic [LANES-1:0] expMask;
        in_valid      = iv;
        in_lane_valid = lv;
        aluop         = op;
        funct         = fn;
        out_ready     = ordy;
        #1;
        busy       = (beatQ.size() > 0);
        expInReady = !busy || (ordy && beatQ.size() == 1);
        if (busy) expMask = beatQ[0];
        else      expMask = '0;
        checkOutput("out_valid",  32'(out_valid),      32'(busy));
        checkOutput("in_ready",   32'(in_ready),       32'(expInReady));
        checkOutput("lane_mask",  32'(out_lane_valid), 32'(expMask));
        checkOutput("ismultiply", 32'(ismultiply),     busy ? 32'(expMul)  : 32'd0);
        checkOutput("alucontrol", 32'(alucontrol),     busy ? 32'(expCtl)  : 32'd0);
        checkOutput("jr",         32'(jr),             busy ? 32'(expJr)   : 32'd0);
        checkOutput("alusrc2",    32'(alusrc2),        busy ? 32'(expSrc2) : 32'd0);
        checkOutput("illegal",    32'(illegal),        busy ? 32'(expIll)  : 32'd0);
        checkOutput("split_busy", 32'(split_busy),     32'(busy && expMulti));
        accNow  = iv && expInReady;
        doneNow = busy && ordy;
    endtask

    // Advance the model across the coming edge, then move to just after it
    task automatic stepClock();
        if (doneNow) void'(beatQ.pop_front());
        if (accNow) loadBundle();
        @(posedge clk);
        #1;
    endtask

    // One cycle with reset high, optionally offering a bundle that must be ignored
    task automatic resetCycle(input bit iv);
        reset     = 1'b1;
        in_valid  = iv;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        beatQ.delete();
    endtask

    initial begin
        logic [LANES*3-1:0] rop;
        logic [LANES*6-1:0] rfn;
        logic [LANES-1:0]   prevMask;
        logic [LANES*4-1:0] prevCtl;
        logic [LANES*3-1:0] splitOps;
        logic [LANES*6-1:0] zeroFn;

        reset         = 1'b1;
        in_valid      = 1'b0;
        in_lane_valid = '0;
        aluop         = '0;
        funct         = '0;
        out_ready     = 1'b0;
        zeroFn        = '0;
        splitOps      = ops4(OP_MUL, OP_ADD, OP_MUL, OP_MUL);
        resetCycle(1'b0);
        resetCycle(1'b0);

        // Reset state
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        stepClock();

        // ADD, SUB, ori, JALR in one beat
        applyStimulus(1'b1, 4'b1111, ops4(OP_R, OP_R, OP_ORI, OP_R), fns4(FN_ADD, FN_SUB, 6'd0, FN_JALR), 1'b1);
        stepClock();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        checkOutput("s1_mask", 32'(out_lane_valid), 32'h0000_000F);
        checkOutput("s1_ctl", 32'(alucontrol), 32'h0000_C162);
        checkOutput("s1_jr", 32'(jr), 32'h0000_0008);
        checkOutput("s1_src2", 32'(alusrc2), 32'h0000_0008);
        stepClock();

        // MUL, ADD, MUL, MUL split into three beats
        applyStimulus(1'b1, 4'b1111, splitOps, zeroFn, 1'b1);
        stepClock();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        checkOutput("s2_beat0", 32'(out_lane_valid), 32'h3);
        checkOutput("s2_busy0", 32'(split_busy), 32'd1);
        stepClock();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        checkOutput("s2_beat1", 32'(out_lane_valid), 32'h4);
        checkOutput("s2_busy1", 32'(split_busy), 32'd1);
        stepClock();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        checkOutput("s2_beat2", 32'(out_lane_valid), 32'h8);
        stepClock();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        checkOutput("s2_done", 32'(out_valid), 32'd0);
        stepClock();

        // Illegal funct in lane 2
        applyStimulus(1'b1, 4'b1111, ops4(OP_R, OP_R, OP_R, OP_R), fns4(FN_ADD, FN_ADD, FN_BAD, FN_ADD), 1'b1);
        stepClock();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        checkOutput("s3_illegal", 32'(illegal), 32'h4);
        checkOutput("s3_ctl2", 32'(alucontrol[11:8]), 32'd0);
        stepClock();

        // All-empty bundle still produces one beat
        applyStimulus(1'b1, 4'b0000, '0, '0, 1'b1);
        stepClock();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        checkOutput("empty_valid", 32'(out_valid), 32'd1);
        checkOutput("empty_mask", 32'(out_lane_valid), 32'd0);
        stepClock();

        // Backpressure for three cycles with a second bundle waiting
        applyStimulus(1'b1, 4'b0111, ops4(OP_ADD, OP_ORI, OP_ADD, OP_ADD), zeroFn, 1'b1);
        stepClock();
        prevMask = out_lane_valid;
        prevCtl  = alucontrol;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 4'b1111, ops4(OP_R, OP_R, OP_R, OP_R), fns4(FN_SUB, FN_SUB, FN_SUB, FN_SUB), 1'b0);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_mask_hold", 32'(out_lane_valid), 32'(prevMask));
            checkOutput("bp_ctl_hold", 32'(alucontrol), 32'(prevCtl));
            stepClock();
        end
        applyStimulus(1'b1, 4'b1111, ops4(OP_R, OP_R, OP_R, OP_R), fns4(FN_SUB, FN_SUB, FN_SUB, FN_SUB), 1'b1);
        stepClock();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        checkOutput("bp_second", 32'(alucontrol), 32'h0000_6666);
        stepClock();

        // Back-to-back bundles with no bubble
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 4'b1111, ops4(OP_ADD, OP_ORI, OP_ADD, OP_ORI), zeroFn, 1'b1);
            checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
            if (c > 0) checkOutput("b2b_out_valid", 32'(out_valid), 32'd1);
            stepClock();
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        stepClock();

        // Reset during the second beat of a split, with a bundle offered at the same time
        applyStimulus(1'b1, 4'b1111, splitOps, zeroFn, 1'b1);
        stepClock();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        stepClock();
        resetCycle(1'b1);
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        checkOutput("rst_split_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_split_ready", 32'(in_ready), 32'd1);
        stepClock();

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            for (int l = 0; l < LANES; l++) begin
                rop[l*3 +: 3] = ($urandom % 3 == 0) ? OP_MUL : 3'($urandom_range(0, 7));
                rfn[l*6 +: 6] = ($urandom % 8 == 0) ? 6'($urandom) : legalFn[$urandom_range(0, 14)];
            end
            if ($urandom % 60 == 0) begin
                resetCycle(1'($urandom % 2));
            end else begin
                applyStimulus(1'($urandom % 4 != 0), 4'($urandom), rop, rfn, 1'($urandom % 3 != 0));
                stepClock();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
